// File: rtl/rv_lsu_ctrl.sv
// Load/store unit controller: turns one MEM-stage request into one or two aligned
// bus beats, merges the returned bytes and reports a single completion pulse.
module rv_lsu_ctrl #(
  parameter int XLEN             = 32,
  parameter int MISALIGNED_SPLIT = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic            req_write_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [4:0]      req_rd_i,
  output logic            bus_req_o,
  input  logic            bus_gnt_i,
  output logic [XLEN-1:0] bus_addr_o,
  output logic            bus_we_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_err_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic [4:0]      rsp_rd_o,
  output logic            rsp_err_o,
  output logic            rsp_misaligned_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SPAN = 2 * XLEN;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t          state;
  logic [OFFW-1:0] off_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic            unsigned_q;
  logic            split_q;
  logic            fault_q;
  logic [NB-1:0]   be_hi_q;
  logic [XLEN-1:0] wdata_hi_q;
  logic [SPAN-1:0] rbuf_q;

  // Extract the addressed bytes from the two-beat span and extend them to XLEN.
  function automatic logic [XLEN-1:0] load_fmt(input logic [SPAN-1:0] span,
                                               input logic [OFFW-1:0] off,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [SPAN-1:0]        sh;
    logic signed [XLEN-1:0] v;
    int                     pad;
    sh  = span >> {off, 3'b000};
    pad = XLEN - (8 << size);
    if (pad < 0) pad = 0;
    v = $signed(sh[XLEN-1:0] << pad);
    if (uns) return $unsigned(v) >> pad;
    return $unsigned(v >>> pad);
  endfunction

  logic [OFFW-1:0] req_off;
  int              req_bytes;
  logic [2*NB-1:0] req_mask;
  logic [SPAN-1:0] req_wspan;
  logic            req_split;
  logic            req_fault;
  logic [XLEN-1:0] beat0_addr;
  logic [SPAN-1:0] rspan;
  logic [XLEN-1:0] rsp_data;

  always_comb begin
    req_off    = req_addr_i[OFFW-1:0];
    req_bytes  = 1 << req_size_i;
    req_mask   = (((2*NB)'(1) << req_bytes) - (2*NB)'(1)) << req_off;
    req_wspan  = {{XLEN{1'b0}}, req_wdata_i} << {req_off, 3'b000};
    req_split  = (int'(req_off) + req_bytes) > NB;
    req_fault  = ((XLEN == 32) && (req_size_i == 2'b11)) ||
                 (req_split && (MISALIGNED_SPLIT == 0));
    beat0_addr = {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // The beat arriving this cycle is merged in so the response can be registered
  // on the same edge that leaves the wait state.
  always_comb begin
    rspan = rbuf_q;
    if (state == WAIT0) rspan[XLEN-1:0]    = bus_rdata_i;
    if (state == WAIT1) rspan[SPAN-1:XLEN] = bus_rdata_i;
    rsp_data = write_q ? '0 : load_fmt(rspan, off_q, size_q, unsigned_q);
  end

  assign req_ready_o = (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      off_q            <= '0;
      size_q           <= '0;
      write_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      split_q          <= 1'b0;
      fault_q          <= 1'b0;
      be_hi_q          <= '0;
      wdata_hi_q       <= '0;
      rbuf_q           <= '0;
      bus_req_o        <= 1'b0;
      bus_addr_o       <= '0;
      bus_we_o         <= 1'b0;
      bus_be_o         <= '0;
      bus_wdata_o      <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= '0;
      rsp_rd_o         <= '0;
      rsp_err_o        <= 1'b0;
      rsp_misaligned_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            off_q            <= req_off;
            size_q           <= req_size_i;
            write_q          <= req_write_i;
            unsigned_q       <= req_unsigned_i;
            split_q          <= req_split;
            fault_q          <= req_fault;
            be_hi_q          <= req_mask[2*NB-1:NB];
            wdata_hi_q       <= req_wspan[SPAN-1:XLEN];
            rbuf_q           <= '0;
            rsp_rd_o         <= req_rd_i;
            rsp_err_o        <= 1'b0;
            rsp_misaligned_o <= 1'b0;
            // Faulting requests never touch the bus, so its outputs keep their old values.
            if (!req_fault) begin
              bus_req_o   <= 1'b1;
              bus_addr_o  <= beat0_addr;
              bus_we_o    <= req_write_i;
              bus_be_o    <= req_mask[NB-1:0];
              bus_wdata_o <= req_wspan[XLEN-1:0];
            end
            state <= REQ0;
          end
        end
        REQ0: begin
          if (fault_q) begin
            rsp_misaligned_o <= 1'b1;
            rsp_valid_o      <= 1'b1;
            rsp_rdata_o      <= rsp_data;
            state            <= RESP;
          end else if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus_rvalid_i) begin
            rbuf_q[XLEN-1:0] <= bus_rdata_i;
            if (bus_err_i || !split_q) begin
              rsp_err_o   <= bus_err_i;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rsp_data;
              state       <= RESP;
            end else begin
              bus_req_o   <= 1'b1;
              bus_addr_o  <= bus_addr_o + XLEN'(NB);
              bus_be_o    <= be_hi_q;
              bus_wdata_o <= wdata_hi_q;
              state       <= REQ1;
            end
          end
        end
        REQ1: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus_rvalid_i) begin
            rbuf_q[SPAN-1:XLEN] <= bus_rdata_i;
            rsp_err_o           <= bus_err_i;
            rsp_valid_o         <= 1'b1;
            rsp_rdata_o         <= rsp_data;
            state               <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
